// File: rtl/gemm_k_sequencer.sv
// gemm_k_sequencer: steps a 2x2 GEMM tile through its K-slices. Each slice
// is fetched, issued once to an external 2x2 MAC array together with the
// running partials, and the array's results become the new partials. After
// k_len slices the tile result is presented until the consumer takes it.
module gemm_k_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               start_i,
    input  logic [7:0]         k_len_i,
    output logic               busy_o,

    input  logic               op_valid_i,
    output logic               op_ready_o,
    input  logic signed [7:0]  op_a0_i,
    input  logic signed [7:0]  op_a1_i,
    input  logic signed [7:0]  op_b0_i,
    input  logic signed [7:0]  op_b1_i,

    output logic               mac_in_valid_o,
    output logic signed [7:0]  mac_a0_o,
    output logic signed [7:0]  mac_a1_o,
    output logic signed [7:0]  mac_b0_o,
    output logic signed [7:0]  mac_b1_o,
    output logic signed [31:0] mac_acc00_o,
    output logic signed [31:0] mac_acc01_o,
    output logic signed [31:0] mac_acc10_o,
    output logic signed [31:0] mac_acc11_o,

    input  logic               mac_out_valid_i,
    input  logic signed [31:0] mac_y00_i,
    input  logic signed [31:0] mac_y01_i,
    input  logic signed [31:0] mac_y10_i,
    input  logic signed [31:0] mac_y11_i,

    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic signed [31:0] res_y00_o,
    output logic signed [31:0] res_y01_o,
    output logic signed [31:0] res_y10_o,
    output logic signed [31:0] res_y11_o,

    output logic               err_timeout_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // The WAIT budget is compared against an 8-bit counter.
    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT);

    state_t             state_q, state_d;
    logic [7:0]         kLen_q, kLen_d;
    logic [7:0]         slice_q, slice_d;
    logic [7:0]         tmo_q, tmo_d;
    logic signed [7:0]  a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
    logic signed [31:0] p00_q, p00_d, p01_q, p01_d, p10_q, p10_d, p11_q, p11_d;
    logic               err_q, err_d;
    logic               macPhase;

    // Next-state and register-update decisions for the tile sequence.
    always_comb begin
        state_d = state_q;
        kLen_d  = kLen_q;
        slice_d = slice_q;
        tmo_d   = tmo_q;
        a0_d    = a0_q;
        a1_d    = a1_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        p00_d   = p00_q;
        p01_d   = p01_q;
        p10_d   = p10_q;
        p11_d   = p11_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    kLen_d  = k_len_i;
                    slice_d = 8'd0;
                    p00_d   = '0;
                    p01_d   = '0;
                    p10_d   = '0;
                    p11_d   = '0;
                    err_d   = 1'b0;
                    state_d = (k_len_i == 8'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (op_valid_i) begin
                    a0_d    = op_a0_i;
                    a1_d    = op_a1_i;
                    b0_d    = op_b0_i;
                    b1_d    = op_b1_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mac_out_valid_i) begin
                    p00_d   = mac_y00_i;
                    p01_d   = mac_y01_i;
                    p10_d   = mac_y10_i;
                    p11_d   = mac_y11_i;
                    slice_d = slice_q + 8'd1;
                    state_d = ((slice_q + 8'd1) == kLen_q) ? DONE : FETCH;
                end else if ((tmo_q + 8'd1) == TimeoutLimit) begin
                    // Array went silent: abandon the tile and flag it.
                    p00_d   = '0;
                    p01_d   = '0;
                    p10_d   = '0;
                    p11_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            kLen_q  <= 8'd0;
            slice_q <= 8'd0;
            tmo_q   <= 8'd0;
            a0_q    <= '0;
            a1_q    <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            p00_q   <= '0;
            p01_q   <= '0;
            p10_q   <= '0;
            p11_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kLen_q  <= kLen_d;
            slice_q <= slice_d;
            tmo_q   <= tmo_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            p00_q   <= p00_d;
            p01_q   <= p01_d;
            p10_q   <= p10_d;
            p11_q   <= p11_d;
            err_q   <= err_d;
        end
    end

    // Operands and seeds are only driven while a slice is in flight.
    assign macPhase = (state_q == ISSUE) || (state_q == WAIT);

    // Output decode from the current state.
    always_comb begin
        busy_o         = (state_q != IDLE);
        op_ready_o     = (state_q == FETCH);
        mac_in_valid_o = (state_q == ISSUE);
        res_valid_o    = (state_q == DONE);
        err_timeout_o  = err_q;

        mac_a0_o    = macPhase ? a0_q  : '0;
        mac_a1_o    = macPhase ? a1_q  : '0;
        mac_b0_o    = macPhase ? b0_q  : '0;
        mac_b1_o    = macPhase ? b1_q  : '0;
        mac_acc00_o = macPhase ? p00_q : '0;
        mac_acc01_o = macPhase ? p01_q : '0;
        mac_acc10_o = macPhase ? p10_q : '0;
        mac_acc11_o = macPhase ? p11_q : '0;

        res_y00_o = res_valid_o ? p00_q : '0;
        res_y01_o = res_valid_o ? p01_q : '0;
        res_y10_o = res_valid_o ? p10_q : '0;
        res_y11_o = res_valid_o ? p11_q : '0;
    end

endmodule

// File: tb/tb_gemm_k_sequencer.sv
// tb_gemm_k_sequencer: drives tiles through the sequencer while acting as
// the 2x2 MAC array; expected results are sums of per-slice outer products.
module tb_gemm_k_sequencer;

    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rstN;
    logic               start;
    logic [7:0]         kLen;
    logic               busy;
    logic               opValid, opReady;
    logic signed [7:0]  opA0, opA1, opB0, opB1;
    logic               macInValid;
    logic signed [7:0]  macA0, macA1, macB0, macB1;
    logic signed [31:0] macAcc00, macAcc01, macAcc10, macAcc11;
    logic               macOutValid;
    logic signed [31:0] macY00, macY01, macY10, macY11;
    logic               resValid, resReady;
    logic signed [31:0] resY00, resY01, resY10, resY11;
    logic               errTimeout;

    gemm_k_sequencer #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rstN),
        .start_i(start), .k_len_i(kLen), .busy_o(busy),
        .op_valid_i(opValid), .op_ready_o(opReady),
        .op_a0_i(opA0), .op_a1_i(opA1), .op_b0_i(opB0), .op_b1_i(opB1),
        .mac_in_valid_o(macInValid),
        .mac_a0_o(macA0), .mac_a1_o(macA1), .mac_b0_o(macB0), .mac_b1_o(macB1),
        .mac_acc00_o(macAcc00), .mac_acc01_o(macAcc01),
        .mac_acc10_o(macAcc10), .mac_acc11_o(macAcc11),
        .mac_out_valid_i(macOutValid),
        .mac_y00_i(macY00), .mac_y01_i(macY01), .mac_y10_i(macY10), .mac_y11_i(macY11),
        .res_valid_o(resValid), .res_ready_i(resReady),
        .res_y00_o(resY00), .res_y01_o(resY01), .res_y10_o(resY10), .res_y11_o(resY11),
        .err_timeout_o(errTimeout)
    );

    int numCompared   = 0;
    int numMismatched = 0;

    // Slice operands for the current tile, and the running sum of outer products.
    logic signed [7:0] tA0 [256];
    logic signed [7:0] tA1 [256];
    logic signed [7:0] tB0 [256];
    logic signed [7:0] tB1 [256];
    int expP [4];

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic setSlice(input int idx, input int a0, input int a1, input int b0, input int b1);
        tA0[idx] = 8'(a0);
        tA1[idx] = 8'(a1);
        tB0[idx] = 8'(b0);
        tB1[idx] = 8'(b1);
    endtask

    task automatic randomSlices(input int k);
        for (int i = 0; i < k; i++)
            setSlice(i, int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    endtask

    task automatic junkMacOut();
        macOutValid = 1'b1;
        macY00 = $urandom;
        macY01 = $urandom;
        macY10 = $urandom;
        macY11 = $urandom;
    endtask

    task automatic quietInputs();
        start       = 1'b0;
        opValid     = 1'b0;
        macOutValid = 1'b0;
        resReady    = 1'b0;
    endtask

    // One full tile: stall<0 picks random FETCH stalls, lat<=0 random MAC latency.
    task automatic applyStimulus(input int k, input int stall, input int lat, input bit strays);
        int st;
        int l;
        int hold;
        int prevP [4];
        @(negedge clk);
        start = 1'b1;
        kLen  = 8'(k);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) expP[i] = 0;
        checkOutput("busy after start", busy, 1);
        checkOutput("err cleared by start", errTimeout, 0);

        for (int s = 0; s < k; s++) begin
            st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int c = 0; c < st; c++) begin
                if (strays) begin
                    junkMacOut();
                    start = 1'b1;
                    kLen  = 8'($urandom);
                end
                checkOutput("op_ready in FETCH", opReady, 1);
                checkOutput("no issue while starved", macInValid, 0);
                @(negedge clk);
                macOutValid = 1'b0;
                start       = 1'b0;
            end
            checkOutput("op_ready before beat", opReady, 1);
            opValid = 1'b1;
            opA0 = tA0[s];
            opA1 = tA1[s];
            opB0 = tB0[s];
            opB1 = tB1[s];
            @(negedge clk);
            opValid = 1'b0;
            opA0 = 8'($urandom);
            opA1 = 8'($urandom);
            opB0 = 8'($urandom);
            opB1 = 8'($urandom);

            checkOutput("issue pulse", macInValid, 1);
            checkOutput("op_ready low in ISSUE", opReady, 0);
            checkOutput("mac_a0", macA0, tA0[s]);
            checkOutput("mac_a1", macA1, tA1[s]);
            checkOutput("mac_b0", macB0, tB0[s]);
            checkOutput("mac_b1", macB1, tB1[s]);
            checkOutput("mac_acc00", macAcc00, expP[0]);
            checkOutput("mac_acc01", macAcc01, expP[1]);
            checkOutput("mac_acc10", macAcc10, expP[2]);
            checkOutput("mac_acc11", macAcc11, expP[3]);
            for (int i = 0; i < 4; i++) prevP[i] = expP[i];
            expP[0] += int'(tA0[s]) * int'(tB0[s]);
            expP[1] += int'(tA0[s]) * int'(tB1[s]);
            expP[2] += int'(tA1[s]) * int'(tB0[s]);
            expP[3] += int'(tA1[s]) * int'(tB1[s]);

            @(negedge clk);
            l = (lat <= 0) ? int'($urandom_range(1, TMO)) : lat;
            for (int c = 1; c < l; c++) begin
                checkOutput("single issue pulse", macInValid, 0);
                checkOutput("mac_b1 held in WAIT", macB1, tB1[s]);
                @(negedge clk);
            end
            checkOutput("still busy in WAIT", busy, 1);
            checkOutput("mac_a1 held in WAIT", macA1, tA1[s]);
            checkOutput("mac_acc11 held in WAIT", macAcc11, prevP[3]);
            macOutValid = 1'b1;
            macY00 = expP[0];
            macY01 = expP[1];
            macY10 = expP[2];
            macY11 = expP[3];
            @(negedge clk);
            macOutValid = 1'b0;
        end

        hold = int'($urandom_range(0, 3));
        for (int c = 0; c <= hold; c++) begin
            checkOutput("res_valid in DONE", resValid, 1);
            checkOutput("no issue in DONE", macInValid, 0);
            checkOutput("res_y00", resY00, expP[0]);
            checkOutput("res_y01", resY01, expP[1]);
            checkOutput("res_y10", resY10, expP[2]);
            checkOutput("res_y11", resY11, expP[3]);
            if (c == hold) begin
                resReady = 1'b1;
                if (strays) begin
                    start = 1'b1;
                    kLen  = 8'd5;
                end
            end else if (strays) begin
                junkMacOut();
                start = 1'b1;
                kLen  = 8'd3;
            end
            @(negedge clk);
            quietInputs();
        end
        checkOutput("res_valid dropped", resValid, 0);
        checkOutput("idle after handshake", busy, 0);
        checkOutput("mac_a0 zero in IDLE", macA0, 0);
        checkOutput("mac_acc00 zero in IDLE", macAcc00, 0);
    endtask

    initial begin
        rstN = 1'b0;
        quietInputs();
        kLen = 8'd0;
        opA0 = '0; opA1 = '0; opB0 = '0; opB1 = '0;
        macY00 = '0; macY01 = '0; macY10 = '0; macY11 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset op_ready", opReady, 0);
        checkOutput("reset mac_in_valid", macInValid, 0);
        checkOutput("reset res_valid", resValid, 0);
        checkOutput("reset err_timeout", errTimeout, 0);
        checkOutput("reset mac_acc10", macAcc10, 0);
        checkOutput("reset res_y11", resY11, 0);
        rstN = 1'b1;

        $display("[TB] two-slice tile with known operands");
        setSlice(0, 1, 3, 5, 6);
        setSlice(1, 2, 4, 7, 8);
        applyStimulus(2, 0, 3, 1'b0);

        $display("[TB] k_len zero tile");
        applyStimulus(0, 0, 0, 1'b1);

        $display("[TB] operand beat withheld for ten cycles");
        randomSlices(1);
        applyStimulus(1, 10, 2, 1'b0);

        $display("[TB] stray mac_out_valid in IDLE");
        @(negedge clk);
        junkMacOut();
        @(negedge clk);
        macOutValid = 1'b0;
        checkOutput("idle ignores mac_out_valid", busy, 0);
        checkOutput("no result from stray", resValid, 0);

        $display("[TB] MAC array never answers");
        randomSlices(2);
        @(negedge clk);
        start = 1'b1;
        kLen  = 8'd2;
        @(negedge clk);
        start   = 1'b0;
        opValid = 1'b1;
        opA0 = tA0[0]; opA1 = tA1[0]; opB0 = tB0[0]; opB1 = tB1[0];
        @(negedge clk);
        opValid = 1'b0;
        checkOutput("timeout tile issue", macInValid, 1);
        @(negedge clk);
        for (int c = 1; c <= TMO; c++) begin
            checkOutput("busy while waiting", busy, 1);
            checkOutput("no result while waiting", resValid, 0);
            checkOutput("no early timeout flag", errTimeout, 0);
            @(negedge clk);
        end
        checkOutput("timeout returns to IDLE", busy, 0);
        checkOutput("timeout flag set", errTimeout, 1);
        checkOutput("timeout gives no result", resValid, 0);
        junkMacOut();
        @(negedge clk);
        macOutValid = 1'b0;
        checkOutput("late answer ignored", busy, 0);
        checkOutput("timeout flag sticky", errTimeout, 1);
        applyStimulus(0, 0, 0, 1'b0);

        $display("[TB] reset pulse during WAIT");
        setSlice(0, 1, 3, 5, 6);
        @(negedge clk);
        start = 1'b1;
        kLen  = 8'd3;
        @(negedge clk);
        start   = 1'b0;
        opValid = 1'b1;
        opA0 = tA0[0]; opA1 = tA1[0]; opB0 = tB0[0]; opB1 = tB1[0];
        @(negedge clk);
        opValid = 1'b0;
        @(negedge clk);
        checkOutput("in WAIT before reset", macA0, 1);
        #1 rstN = 1'b0;
        #1;
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset mac_a0", macA0, 0);
        checkOutput("async reset mac_b1", macB1, 0);
        checkOutput("async reset op_ready", opReady, 0);
        checkOutput("async reset res_valid", resValid, 0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1, 0, 1, 1'b0);

        $display("[TB] randomized tiles");
        for (int t = 0; t < 25; t++) begin
            int k;
            k = int'($urandom_range(0, 5));
            randomSlices(k);
            applyStimulus(k, -1, 0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/gemm_k_sequencer.md
GEMM_K_SEQUENCER -- requirements
Module: gemm_k_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 64, max cycles WAIT may last for one mac_out_valid (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; begins a GEMM tile; sampled only in IDLE.
REQ-005 k_len  input  8  number of K-slices for the tile; sampled with start.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 op_valid  input  1  operand beat valid.
REQ-008 op_ready  output  1  sequencer accepts operand beat.
REQ-009 op_a0, op_a1, op_b0, op_b1  input  8 each, signed  one K-slice: A column k (rows 0,1), B row k (cols 0,1).
REQ-010 mac_in_valid  output  1  issue pulse to 2x2 MAC array.
REQ-011 mac_a0, mac_a1, mac_b0, mac_b1  output  8 each, signed  operands to MAC array.
REQ-012 mac_acc00, mac_acc01, mac_acc10, mac_acc11  output  32 each, signed  accumulator seeds to MAC array.
REQ-013 mac_out_valid  input  1  MAC array result valid.
REQ-014 mac_y00, mac_y01, mac_y10, mac_y11  input  32 each, signed  MAC array results.
REQ-015 res_valid  output  1  final 2x2 result available.
REQ-016 res_ready  input  1  consumer accepts result.
REQ-017 res_y00, res_y01, res_y10, res_y11  output  32 each, signed  final tile result.
REQ-018 err_timeout  output  1  sticky; set when a WAIT exceeds TIMEOUT; cleared by next accepted start.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, ISSUE, WAIT, DONE.
REQ-020 IDLE: start=1 and k_len>0 -> FETCH, slice counter=0, partials P00..P11=0, err_timeout=0; start=1 and k_len=0 -> DONE with result 0; start=0 -> stay.
REQ-021 FETCH: op_ready=1 (only here); on op_valid&&op_ready, register the four operands -> ISSUE; otherwise stay.
REQ-022 ISSUE: mac_in_valid=1 for exactly one cycle; mac_a*/mac_b* = registered operands; mac_acc* = current partials (0 for slice 0) -> WAIT, timeout counter=0.
REQ-023 mac_a*, mac_b*, mac_acc* SHALL hold their values in WAIT and be 0 in IDLE.
REQ-024 WAIT: on mac_out_valid, P** <= mac_y** and counter+1; if counter+1==k_len -> DONE, else -> FETCH.
REQ-025 WAIT: timeout counter increments each cycle without mac_out_valid; reaching TIMEOUT -> IDLE, err_timeout=1, partials discarded, res_valid not asserted.
REQ-026 DONE: res_valid=1, res_y** = P**, stable until res_valid&&res_ready; then -> IDLE in the following cycle.
REQ-027 mac_out_valid outside WAIT SHALL be ignored (no state or partial change).
REQ-028 start outside IDLE SHALL be ignored; start and res_ready in same DONE cycle: start ignored.
REQ-029 Arithmetic: sequencer does no arithmetic beyond passing values; 32-bit wrap is the MAC array's; counter is 8-bit, k_len up to 255.
REQ-030 Minimum per-slice cycle cost: FETCH 1 + ISSUE 1 + WAIT (MAC latency) cycles.

Reset
REQ-031 rst_n=0 SHALL force IDLE immediately, any state, including mid-tile.
REQ-032 Reset values: busy, op_ready, mac_in_valid, res_valid, err_timeout = 0; all data outputs, partials, counters = 0.
REQ-033 First start is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-034 k_len=2, slices (1,3,5,6) then (2,4,7,8) -> second issue mac_acc = {5,6,15,18}; res_y = {19,22,43,50}, res_valid held until res_ready.
REQ-035 k_len=0 start -> DONE next cycle, res_y all 0, mac_in_valid never asserted.
REQ-036 op_valid withheld 10 cycles in FETCH -> op_ready stays 1, mac_in_valid stays 0; proceeds on first op_valid.
REQ-037 TIMEOUT=8, mac_out_valid never returned -> after 8 WAIT cycles IDLE, err_timeout=1, no res_valid; next start clears err_timeout.
REQ-038 rst_n pulsed low during WAIT of k_len=3 tile -> all outputs 0 immediately; fresh k_len=1 tile (1,3,5,6) gives {5,6,15,18}.
REQ-039 Stray mac_out_valid in IDLE/FETCH and start during busy -> no state, partial or result change.
